// File: rtl/uart_pkg.sv
// Frame constants and receiver state encoding shared by the UART receiver and transmitter.
package uart_pkg;

  localparam int unsigned OVERSAMPLE  = 16;
  localparam int unsigned VOTE_FIRST  = 7;
  localparam int unsigned VOTE_DECIDE = 9;
  localparam int unsigned DATA_BITS   = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } rx_state_e;

endpackage

// File: rtl/uart_receiver_if.sv
// Serial pin plus received-byte outputs of the UART receiver.
interface uart_receiver_if;
  import uart_pkg::*;

  logic                 rx;
  logic [DATA_BITS-1:0] data;
  logic                 data_valid;
  logic                 framing_error;
  logic                 busy;

  // master: the receiver itself; slave: the pin driver and byte consumer
  modport master (input rx, output data, output data_valid, output framing_error, output busy);
  modport slave  (output rx, input data, input data_valid, input framing_error, input busy);

endinterface

// File: rtl/uart_baud_tick.sv
// Oversample prescaler: one-cycle tick every CLKS_PER_TICK clocks, restartable via clear.
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_TICK = 651
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int unsigned     CntW    = $clog2(CLKS_PER_TICK);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_TICK - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear || (cnt_q == CntLast)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = (cnt_q == CntLast);

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop synchroniser, 16x oversampling, 3-sample majority vote per bit.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_TICK = 651
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_receiver_if.master bus
);

  localparam logic [3:0] VoteS0     = 4'(VOTE_FIRST);
  localparam logic [3:0] VoteS1     = 4'(VOTE_FIRST + 1);
  localparam logic [3:0] VoteDecide = 4'(VOTE_DECIDE);
  localparam logic [2:0] LastBit    = 3'(DATA_BITS - 1);

  logic                 sync1_q, rxs_q, rxs_d_q;
  rx_state_e            state_q;
  logic [3:0]           tick_cnt_q;
  logic [2:0]           bit_idx_q;
  logic [1:0]           sample_q;
  logic [DATA_BITS-1:0] shift_q, data_q;
  logic                 data_valid_q, framing_error_q, busy_q;

  logic       start_edge, tick, vote, decide, wrap;
  logic [3:0] tick_pos;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
      rxs_d_q <= 1'b1;
    end else begin
      sync1_q <= bus.rx;
      rxs_q   <= sync1_q;
      rxs_d_q <= rxs_q;
    end
  end

  assign start_edge = (state_q == StIdle) && rxs_d_q && !rxs_q;

  uart_baud_tick #(
    .CLKS_PER_TICK(CLKS_PER_TICK)
  ) u_baud_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(start_edge),
    .tick (tick)
  );

  // Position of the current tick within the bit; 0 marks the 15->0 wrap.
  assign tick_pos = tick_cnt_q + 4'd1;
  assign decide   = tick && (tick_pos == VoteDecide);
  assign wrap     = tick && (tick_pos == 4'd0);
  assign vote     = (sample_q[0] & sample_q[1]) | (sample_q[0] & rxs_q) | (sample_q[1] & rxs_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      tick_cnt_q      <= '0;
      bit_idx_q       <= '0;
      sample_q        <= '0;
      shift_q         <= '0;
      data_q          <= '0;
      data_valid_q    <= 1'b0;
      framing_error_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      data_valid_q    <= 1'b0;
      framing_error_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start_edge) begin
            state_q    <= StStart;
            tick_cnt_q <= '0;
            busy_q     <= 1'b1;
          end
        end
        // A held-low line must go high before a new start edge is trusted.
        StWaitHigh: begin
          if (rxs_q) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          if (tick) tick_cnt_q <= tick_pos;
          if (tick && (tick_pos == VoteS0)) sample_q[0] <= rxs_q;
          if (tick && (tick_pos == VoteS1)) sample_q[1] <= rxs_q;
          if (decide) begin
            if (state_q == StStart) begin
              if (vote) begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
              end
            end else if (state_q == StData) begin
              shift_q <= {vote, shift_q[DATA_BITS-1:1]};
            end else if (vote) begin
              // Good stop: leave at mid-stop so a back-to-back start is not missed.
              data_q       <= shift_q;
              data_valid_q <= 1'b1;
              state_q      <= StIdle;
              busy_q       <= 1'b0;
            end else begin
              framing_error_q <= 1'b1;
              state_q         <= StWaitHigh;
            end
          end
          if (wrap) begin
            if (state_q == StStart) begin
              state_q   <= StData;
              bit_idx_q <= '0;
            end else if (state_q == StData) begin
              if (bit_idx_q == LastBit) state_q <= StStop;
              else bit_idx_q <= bit_idx_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus.data          = data_q;
  assign bus.data_valid    = data_valid_q;
  assign bus.framing_error = framing_error_q;
  assign bus.busy          = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Randomised self-checking bench for uart_receiver against a frame-level scoreboard.
module tb_uart_receiver;

  localparam int unsigned CPT     = 4;
  localparam int unsigned BIT_CYC = 16 * CPT;
  // rx falls after edge c0; detection edge E = c0+3; stop decided at tick 153 after E.
  localparam int unsigned PULSE_LAT = 3 + 153 * CPT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_receiver_if bus ();

  uart_receiver #(
    .CLKS_PER_TICK(CPT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    int         at;
    bit         ferr;
    logic [7:0] b;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e_m;
  logic [7:0] model_data = 8'h00;

  // Scoreboard: every pulse must match the next expected frame in cycle, kind and byte.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      model_data = 8'h00;
    end else begin
      if (bus.data_valid || bus.framing_error) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_pulse", {30'd0, bus.data_valid, bus.framing_error}, 32'd0);
        end else begin
          e_m = exp_q.pop_front();
          check_eq("pulse_cycle", cyc, e_m.at);
          check_eq("pulse_kind", {30'd0, bus.data_valid, bus.framing_error},
                   e_m.ferr ? 32'd1 : 32'd2);
          if (!e_m.ferr) model_data = e_m.b;
        end
      end else if (exp_q.size() > 0 && cyc > exp_q[0].at) begin
        check_eq("missing_pulse", cyc, exp_q[0].at);
        void'(exp_q.pop_front());
      end
      check_eq("data_hold", {24'd0, bus.data}, {24'd0, model_data});
    end
  end

  // Called at a negedge. cut>0 abandons the frame after that many cycles (no expectation).
  task automatic send_frame(input logic [7:0] b, input bit stop, input int glitch_bit,
                            input int cut, input int hold_low);
    logic [9:0] bits;
    int         t;
    bits = {stop, b, 1'b0};
    t    = 0;
    if (cut == 0) exp_q.push_back('{cyc + PULSE_LAT, !stop, b});
    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < int'(BIT_CYC); i++) begin
        if (cut != 0 && t == cut) begin
          bus.rx = 1'b1;
          return;
        end
        // 4-cycle inversion hitting only the tick-8 vote sample
        bus.rx = bits[n] ^ ((n == glitch_bit) && (i >= 31) && (i < 35));
        t++;
        @(negedge clk);
      end
    end
    repeat (hold_low) @(negedge clk);
    bus.rx = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_data"}, {24'd0, bus.data}, 32'd0);
    check_eq({tag, "_valid"}, {31'd0, bus.data_valid}, 32'd0);
    check_eq({tag, "_ferr"}, {31'd0, bus.framing_error}, 32'd0);
    check_eq({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1);
  end

  initial begin
    int c0;
    int mode;
    logic [7:0] rb;
    bus.rx = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Ideal frame
    fork
      send_frame(8'hA5, 1'b1, -1, 0, 0);
      begin
        repeat (100) @(negedge clk);
        check_eq("t1_busy_mid", {31'd0, bus.busy}, 32'd1);
      end
    join
    repeat (20) @(negedge clk);
    check_eq("t1_busy_after", {31'd0, bus.busy}, 32'd0);
    check_eq("t1_data", {24'd0, bus.data}, 32'hA5);

    // False start: 20-cycle low pulse
    c0 = cyc;
    bus.rx = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("t2_busy_start", {31'd0, bus.busy}, 32'd1);
    repeat (10) @(negedge clk);
    bus.rx = 1'b1;
    while (cyc < c0 + 3 + 40) @(negedge clk);
    check_eq("t2_busy_gone", {31'd0, bus.busy}, 32'd0);
    repeat (20) @(negedge clk);

    // Framing error followed by a 200-cycle break
    fork
      send_frame(8'h3C, 1'b0, -1, 0, 200);
      begin
        repeat (700) @(negedge clk);
        check_eq("t3_busy_break", {31'd0, bus.busy}, 32'd1);
      end
    join
    repeat (10) @(negedge clk);
    check_eq("t3_busy_released", {31'd0, bus.busy}, 32'd0);
    check_eq("t3_data_kept", {24'd0, bus.data}, 32'hA5);

    // Back-to-back frames
    send_frame(8'h00, 1'b1, -1, 0, 0);
    send_frame(8'hFF, 1'b1, -1, 0, 0);
    repeat (10) @(negedge clk);
    check_eq("t4_data", {24'd0, bus.data}, 32'hFF);

    // Glitch on data bit 3
    send_frame(8'h55, 1'b1, 4, 0, 0);
    repeat (10) @(negedge clk);
    check_eq("t5_data", {24'd0, bus.data}, 32'h55);

    // Reset during data bit 4, then a clean frame
    send_frame(8'hC3, 1'b1, -1, 5 * BIT_CYC + 20, 0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("t6_in_reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_reset_outputs("t6_after_reset");
    send_frame(8'h81, 1'b1, -1, 0, 0);
    repeat (10) @(negedge clk);
    check_eq("t6_data", {24'd0, bus.data}, 32'h81);

    // Randomised mix of good, glitched, framing-error frames and idle-line glitches
    for (int k = 0; k < 40; k++) begin
      mode = $urandom_range(0, 9);
      rb   = 8'($urandom_range(0, 255));
      if (mode == 0) begin
        bus.rx = 1'b0;
        repeat ($urandom_range(1, 20)) @(negedge clk);
        bus.rx = 1'b1;
        repeat (60) @(negedge clk);
      end else if (mode == 1) begin
        send_frame(rb, 1'b0, -1, 0, $urandom_range(0, 100));
        repeat ($urandom_range(5, 20)) @(negedge clk);
      end else if (mode == 2) begin
        send_frame(rb, 1'b1, $urandom_range(0, 9), 0, 0);
      end else begin
        send_frame(rb, 1'b1, -1, 0, 0);
        repeat ($urandom_range(0, 30)) @(negedge clk);
      end
    end

    repeat (BIT_CYC * 11) @(negedge clk);
    check_eq("queue_drained", exp_q.size(), 32'd0);
    check_eq("final_busy", {31'd0, bus.busy}, 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Asynchronous serial receiver for 8N1 frames: the receive-side counterpart of the existing UART transmitter, sharing its baud rate and frame format. It synchronises the `rx` pin, validates the start bit, and recovers eight data bits LSB-first with 16x oversampling and 3-sample majority voting. Each good frame produces a one-cycle `data_valid` pulse; a bad stop bit produces a `framing_error` pulse. It sits beside the transmitter in the top level, driven from a dedicated input pin.

## Interface

**Parameters**
- `CLKS_PER_TICK`, default 651: clock cycles per oversample tick (100 MHz / (9600 × 16)); must be ≥ 2.
- `OVERSAMPLE`, fixed at 16: ticks per bit.

**Ports** (name, direction, width, meaning)
- `clk`, in, 1: the only clock.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `rx`, in, 1: serial input; idles high and is asynchronous to `clk`.
- `data`, out, 8: last correctly received byte; holds until the next good frame.
- `data_valid`, out, 1: one-cycle pulse when `data` updates.
- `framing_error`, out, 1: one-cycle pulse when the stop bit is sampled low.
- `busy`, out, 1: high in every state except IDLE.

## Operation

- **Synchroniser:** two flops on `rx`, both reset to 1. The synchronised value is `rxs`, and `rxs_d` is `rxs` delayed by one flop.
- **Tick generator:** a counter counts 0..CLKS_PER_TICK-1 and `tick` pulses on its terminal count.
  - The counter is forced to 0 in the cycle a start edge is detected, so tick k lands exactly k × CLKS_PER_TICK cycles after the detection cycle E.
- **Tick counter:** 4 bits. It counts ticks within a bit and wraps 15→0, which advances the bit index.
- **Majority vote:** `rxs` is sampled on ticks 7, 8 and 9 of each bit. The bit value is the majority of the three samples, and the decision is taken at tick 9.
- **State machine:**
  - IDLE: when `rxs_d`=1 and `rxs`=0 (falling edge), go to START, clear the tick counter and the prescaler.
  - START: at the tick-9 decision, a majority of 1 is a false start and returns to IDLE with no output. A majority of 0 stays in START until tick 15 wraps, then goes to DATA with bit index 0.
  - DATA: at tick 9 the voted bit shifts into the shift register MSB-first, so the LSB arrives first. After bit index 7 wraps, go to STOP.
  - STOP: at the tick-9 decision:
    - Majority 1: load `data` from the shift register, pulse `data_valid`, go to IDLE. The receiver returns at mid-stop so it can resync to a back-to-back start bit.
    - Majority 0: pulse `framing_error`, leave `data` unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rxs`=1, then go to IDLE. This keeps a line held low (break) from being taken as a new start bit.
- **Reset values:** `data`=0x00, `data_valid`=0, `framing_error`=0, `busy`=0, state IDLE, all counters 0.
- **Reset mid-frame:** the frame is discarded, no pulse is produced, and the receiver restarts in IDLE.

## Timing

- Latency from an `rx` pin edge to `rxs` is 2 cycles.
- Bit n (start=0, data=1..8, stop=9) is decided at tick 16n+9.
- `data_valid` / `framing_error` is high exactly in cycle E + 153 × CLKS_PER_TICK + 1, for one cycle only.
- `data` changes in the same cycle that `data_valid` rises.
- `busy` rises in cycle E+1. It falls in the cycle after the stop decision, or when WAIT_HIGH exits.
- A falling edge in the first cycle after returning to IDLE is accepted as a new start.
- A glitch shorter than 2 of the 3 vote samples cannot flip a bit or start a frame.

## Structure

- **Package `uart_pkg`:** the state enum (IDLE, START, DATA, STOP, WAIT_HIGH), `OVERSAMPLE`=16, `VOTE_FIRST`=7, `VOTE_DECIDE`=9, `DATA_BITS`=8. The transmitter shares the frame constants.
- **Sub-module `uart_baud_tick`:** the prescaler, with a `clear` input and a `tick` output. The RX top instantiates it and the transmitter may reuse it.
- **Main module:** the synchroniser, the vote and the state machine stay in `uart_receiver`.

## Test plan

Simulation uses CLKS_PER_TICK=4, so one bit is 64 clock cycles.

1. Send 0xA5 as an ideal 8N1 frame. Expect `data`=0xA5, `data_valid` high for one cycle at E+613, `framing_error` never high, and `busy` low afterwards.
2. Drive `rx` low for 20 cycles, then high. Expect a false start: no pulse, IDLE, and `busy` low by E+40.
3. Send 0x3C with the stop bit driven 0, then hold `rx` low for 200 cycles, then release. Expect a `framing_error` pulse, `data` still showing the previous byte, and no new frame until `rx` goes high.
4. Send 0x00 and 0xFF back-to-back with no idle gap. Expect two `data_valid` pulses 640 cycles apart, with `data` 0x00 then 0xFF.
5. Send 0x55 with a 4-cycle inverted glitch at tick 8 of data bit 3. Expect `data`=0x55 (the majority vote rejects the glitch).
6. Assert `rst_n` low during data bit 4 of a frame, release it, then send 0x81. Expect no output from the first frame, all outputs at their reset values, and then `data`=0x81 with one `data_valid` pulse.
